// File: rtl/decode_mod_if.sv
// Bundle of fetch-side inputs, writeback port and ID/EX outputs of the decode stage.
// The slave modport is the decode stage's view; master is the surrounding pipeline.
interface decode_mod_if #(parameter int XLEN = 64);
  logic [31:0]     IFID_instreg;
  logic [XLEN-1:0] IFID_npc;
  logic            IFID_ready;
  logic            EXID_stall;
  logic            EXIF_branch;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            IDEX_ready;
  logic [XLEN-1:0] IDEX_npc;
  logic [63:0]     opcode;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [5:0]      rd;
  logic [19:0]     immediate;
  logic [5:0]      IDEX_rs1reg;
  logic [5:0]      IDEX_rs2reg;
  logic            IDIF_stall;

  modport master (
    output IFID_instreg, IFID_npc, IFID_ready, EXID_stall, EXIF_branch,
           wb_en, wb_rd, wb_data,
    input  IDEX_ready, IDEX_npc, opcode, rs1, rs2, rd, immediate,
           IDEX_rs1reg, IDEX_rs2reg, IDIF_stall
  );

  modport slave (
    input  IFID_instreg, IFID_npc, IFID_ready, EXID_stall, EXIF_branch,
           wb_en, wb_rd, wb_data,
    output IDEX_ready, IDEX_npc, opcode, rs1, rs2, rd, immediate,
           IDEX_rs1reg, IDEX_rs2reg, IDIF_stall
  );
endinterface

// File: rtl/decode_mod.sv
// RV64I instruction-decode stage: decodes one instruction per cycle into the
// ID/EX register, owns the 32x64 register file, and raises load-use stalls.
module decode_mod #(
  parameter int XLEN = 64
) (
  input  logic        clk,
  input  logic        reset,
  decode_mod_if.slave bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  logic [31:0]     instr;
  logic [6:0]      op;
  logic [2:0]      funct3;
  logic [4:0]      rs1_a;
  logic [4:0]      rs2_a;
  logic [4:0]      rd_a;
  fmt_e            fmt;
  logic            writes_rd;
  logic            uses_rs1;
  logic            uses_rs2;
  logic [6:0]      funct7;
  logic [19:0]     imm;
  logic [XLEN-1:0] regs [32];
  logic            wb_hit;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            hazard;

  logic            idex_ready;
  logic [XLEN-1:0] idex_npc;
  logic [63:0]     idex_opcode;
  logic [XLEN-1:0] idex_rs1;
  logic [XLEN-1:0] idex_rs2;
  logic [5:0]      idex_rd;
  logic [19:0]     idex_imm;
  logic [5:0]      idex_rs1reg;
  logic [5:0]      idex_rs2reg;

  assign instr  = bus.IFID_instreg;
  assign op     = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1_a  = instr[19:15];
  assign rs2_a  = instr[24:20];
  assign rd_a   = instr[11:7];

  // Map the major opcode onto an encoding format; anything unknown is a NOP.
  always_comb begin
    fmt = FMT_NONE;
    case (op)
      OP_REG, OP_REG32:                   fmt = FMT_R;
      OP_IMM, OP_IMM32, OP_LOAD, OP_JALR: fmt = FMT_I;
      OP_STORE:                           fmt = FMT_S;
      OP_BRANCH:                          fmt = FMT_B;
      OP_LUI, OP_AUIPC:                   fmt = FMT_U;
      OP_JAL:                             fmt = FMT_J;
      default:                            fmt = FMT_NONE;
    endcase
  end

  // Per-format operand usage, funct7 passthrough and immediate assembly.
  always_comb begin
    writes_rd = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    funct7    = 7'd0;
    imm       = 20'd0;
    case (fmt)
      FMT_R: begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        funct7    = instr[31:25];
      end
      FMT_I: begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        imm       = {{8{instr[31]}}, instr[31:20]};
        if ((op == OP_IMM || op == OP_IMM32) &&
            (funct3 == 3'b001 || funct3 == 3'b101))
          funct7 = instr[31:25];
      end
      FMT_S: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm      = {{8{instr[31]}}, instr[31:25], instr[11:7]};
      end
      FMT_B: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm      = {{8{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8]};
      end
      FMT_U: begin
        writes_rd = 1'b1;
        imm       = instr[31:12];
      end
      FMT_J: begin
        writes_rd = 1'b1;
        imm       = {instr[31], instr[19:12], instr[20], instr[30:21]};
      end
      default: begin
        writes_rd = 1'b0;
      end
    endcase
    if (rd_a == 5'd0)
      writes_rd = 1'b0;
  end

  assign wb_hit = bus.wb_en && (bus.wb_rd != 5'd0);

  // Register file write port; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (wb_hit) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Read ports with writeback bypass so a same-cycle write is seen immediately.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_a != 5'd0)
      rs1_val = (wb_hit && bus.wb_rd == rs1_a) ? bus.wb_data : regs[rs1_a];
    if (rs2_a != 5'd0)
      rs2_val = (wb_hit && bus.wb_rd == rs2_a) ? bus.wb_data : regs[rs2_a];
  end

  assign hazard = idex_ready && (idex_opcode[6:0] == OP_LOAD) && idex_rd[5] &&
                  ((uses_rs1 && rs1_a == idex_rd[4:0]) ||
                   (uses_rs2 && rs2_a == idex_rd[4:0]));

  assign bus.IDIF_stall = bus.EXID_stall | hazard;

  // ID/EX register: flush beats stall, stall holds, hazard bubbles, else capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_ready  <= 1'b0;
      idex_npc    <= '0;
      idex_opcode <= '0;
      idex_rs1    <= '0;
      idex_rs2    <= '0;
      idex_rd     <= '0;
      idex_imm    <= '0;
      idex_rs1reg <= '0;
      idex_rs2reg <= '0;
    end else if (bus.EXIF_branch) begin
      idex_ready <= 1'b0;
    end else if (!bus.EXID_stall) begin
      if (hazard) begin
        idex_ready <= 1'b0;
      end else if (bus.IFID_ready) begin
        idex_ready  <= 1'b1;
        idex_npc    <= bus.IFID_npc;
        idex_opcode <= {47'd0, funct7, funct3, op};
        idex_rs1    <= rs1_val;
        idex_rs2    <= rs2_val;
        idex_rd     <= {writes_rd, rd_a};
        idex_imm    <= imm;
        idex_rs1reg <= {uses_rs1, rs1_a};
        idex_rs2reg <= {uses_rs2, rs2_a};
      end else begin
        idex_ready <= 1'b0;
      end
    end
  end

  assign bus.IDEX_ready  = idex_ready;
  assign bus.IDEX_npc    = idex_npc;
  assign bus.opcode      = idex_opcode;
  assign bus.rs1         = idex_rs1;
  assign bus.rs2         = idex_rs2;
  assign bus.rd          = idex_rd;
  assign bus.immediate   = idex_imm;
  assign bus.IDEX_rs1reg = idex_rs1reg;
  assign bus.IDEX_rs2reg = idex_rs2reg;

endmodule

// File: tb/tb_decode_mod.sv
// Bench for decode_mod: directed instruction vectors, a reference model of the
// decode stage, and literal expectations for the key encodings.
module tb_decode_mod;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decode_mod_if bus ();

  decode_mod dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        ready;
    logic [63:0] npc;
    logic [63:0] opc;
    logic [63:0] v1;
    logic [63:0] v2;
    logic [5:0]  rd;
    logic [5:0]  r1;
    logic [5:0]  r2;
    logic [19:0] imm;
  } idex_t;

  idex_t       m_idex = '0;
  logic [63:0] m_regs [32];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Decode an instruction from the ISA's field layouts; immediates are derived
  // from the architectural byte offset rather than from bit shuffling.
  function automatic idex_t model_decode(input logic [31:0] ins, input logic [63:0] pc,
                                         input logic [63:0] a, input logic [63:0] b);
    idex_t      d;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         r_t, i_t, ld, jr, s_t, b_t, u_t, j_t;
    int         val;
    op  = ins[6:0];
    f3  = ins[14:12];
    r_t = (op == 7'h33) || (op == 7'h3b);
    i_t = (op == 7'h13) || (op == 7'h1b);
    ld  = (op == 7'h03);
    jr  = (op == 7'h67);
    s_t = (op == 7'h23);
    b_t = (op == 7'h63);
    u_t = (op == 7'h37) || (op == 7'h17);
    j_t = (op == 7'h6f);
    val = 0;
    if (i_t || ld || jr)
      val = int'($signed(ins[31:20]));
    else if (s_t)
      val = int'($signed({ins[31:25], ins[11:7]}));
    else if (b_t)
      val = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})) / 2;
    else if (u_t)
      val = int'({12'd0, ins[31:12]});
    else if (j_t)
      val = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})) / 2;
    f7      = (r_t || (i_t && (f3 == 3'd1 || f3 == 3'd5))) ? ins[31:25] : 7'd0;
    d.ready = 1'b1;
    d.npc   = pc;
    d.opc   = {47'd0, f7, f3, op};
    d.v1    = a;
    d.v2    = b;
    d.imm   = val[19:0];
    d.rd    = {((r_t || i_t || u_t || j_t || jr || ld) && (ins[11:7] != 5'd0)), ins[11:7]};
    d.r1    = {(r_t || i_t || s_t || b_t || ld || jr), ins[19:15]};
    d.r2    = {(r_t || s_t || b_t), ins[24:20]};
    return d;
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] a);
    if (a == 5'd0)
      return 64'd0;
    if (bus.wb_en && bus.wb_rd == a)
      return bus.wb_data;
    return m_regs[a];
  endfunction

  // A load sitting in ID/EX whose destination the current instruction reads.
  function automatic logic m_hazard();
    idex_t cur;
    cur = model_decode(bus.IFID_instreg, bus.IFID_npc, 64'd0, 64'd0);
    return m_idex.ready && (m_idex.opc[6:0] == 7'h03) && m_idex.rd[5] &&
           ((cur.r1[5] && cur.r1[4:0] == m_idex.rd[4:0]) ||
            (cur.r2[5] && cur.r2[4:0] == m_idex.rd[4:0]));
  endfunction

  // Reference model update on each clock edge or asynchronous reset.
  always @(posedge clk or negedge reset) begin
    idex_t nxt;
    if (!reset) begin
      m_idex = '0;
      for (int i = 0; i < 32; i++)
        m_regs[i] = 64'd0;
    end else begin
      nxt = model_decode(bus.IFID_instreg, bus.IFID_npc,
                         m_read(bus.IFID_instreg[19:15]), m_read(bus.IFID_instreg[24:20]));
      if (bus.EXIF_branch)
        m_idex.ready = 1'b0;
      else if (bus.EXID_stall)
        m_idex = m_idex;
      else if (m_hazard())
        m_idex.ready = 1'b0;
      else if (bus.IFID_ready)
        m_idex = nxt;
      else
        m_idex.ready = 1'b0;
      if (bus.wb_en && bus.wb_rd != 5'd0)
        m_regs[bus.wb_rd] = bus.wb_data;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    checkOutput("cmp_ready", {63'd0, bus.IDEX_ready}, {63'd0, m_idex.ready});
    checkOutput("cmp_stall", {63'd0, bus.IDIF_stall}, {63'd0, (bus.EXID_stall | m_hazard())});
    if (m_idex.ready) begin
      checkOutput("cmp_npc", bus.IDEX_npc, m_idex.npc);
      checkOutput("cmp_opcode", bus.opcode, m_idex.opc);
      checkOutput("cmp_rs1", bus.rs1, m_idex.v1);
      checkOutput("cmp_rs2", bus.rs2, m_idex.v2);
      checkOutput("cmp_rd", {58'd0, bus.rd}, {58'd0, m_idex.rd});
      checkOutput("cmp_imm", {44'd0, bus.immediate}, {44'd0, m_idex.imm});
      checkOutput("cmp_rs1reg", {58'd0, bus.IDEX_rs1reg}, {58'd0, m_idex.r1});
      checkOutput("cmp_rs2reg", {58'd0, bus.IDEX_rs2reg}, {58'd0, m_idex.r2});
    end
  end

  task automatic setInputs(input logic [31:0] ins, input logic [63:0] pc, input logic rdy,
                           input logic stall, input logic br, input logic wen,
                           input logic [4:0] wrd, input logic [63:0] wdata);
    bus.IFID_instreg = ins;
    bus.IFID_npc     = pc;
    bus.IFID_ready   = rdy;
    bus.EXID_stall   = stall;
    bus.EXIF_branch  = br;
    bus.wb_en        = wen;
    bus.wb_rd        = wrd;
    bus.wb_data      = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic [63:0] pc, input logic rdy,
                               input logic stall, input logic br, input logic wen,
                               input logic [4:0] wrd, input logic [63:0] wdata);
    setInputs(ins, pc, rdy, stall, br, wen, wrd, wdata);
    tick();
  endtask

  localparam logic [31:0] ADDI_X6  = 32'h00528313;
  localparam logic [31:0] ADD_X7   = 32'h005283B3;
  localparam logic [31:0] LD_X5    = 32'h0000B283;
  localparam logic [31:0] BEQ_M8   = 32'hFE208CE3;
  localparam logic [31:0] JAL_800  = 32'h001000EF;
  localparam logic [31:0] LUI_X3   = 32'hABCDE1B7;
  localparam logic [31:0] ADDI_X0  = 32'h00100013;
  localparam logic [31:0] SW_M4    = 32'hFE20AE23;
  localparam logic [31:0] SRAI_X4  = 32'h4032D213;
  localparam logic [31:0] BAD_OP   = 32'h0000007F;

  initial begin
    reset = 1'b0;
    setInputs(32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    tick();
    checkOutput("lit_reset_ready", {63'd0, bus.IDEX_ready}, 64'd0);

    // Write x5 then decode addi x6,x5,5
    applyStimulus(32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 64'h1234);
    applyStimulus(ADDI_X6, 64'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    checkOutput("lit_addi_rs1", bus.rs1, 64'h1234);
    checkOutput("lit_addi_imm", {44'd0, bus.immediate}, 64'h00005);
    checkOutput("lit_addi_rd", {58'd0, bus.rd}, 64'h26);
    checkOutput("lit_addi_rs1reg", {58'd0, bus.IDEX_rs1reg}, 64'h25);
    checkOutput("lit_addi_rs2used", {63'd0, bus.IDEX_rs2reg[5]}, 64'd0);
    checkOutput("lit_addi_opcode", bus.opcode, 64'h0013);
    checkOutput("lit_addi_npc", bus.IDEX_npc, 64'h1000);
    checkOutput("lit_addi_ready", {63'd0, bus.IDEX_ready}, 64'd1);

    // Same-cycle writeback bypass
    applyStimulus(ADD_X7, 64'h1004, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 64'hAA);
    checkOutput("lit_byp_rs1", bus.rs1, 64'hAA);
    checkOutput("lit_byp_rs2", bus.rs2, 64'hAA);
    checkOutput("lit_byp_opcode", bus.opcode, 64'h0033);

    // Asynchronous reset while IDEX_ready is high
    setInputs(32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    #1 reset = 1'b0;
    #1;
    checkOutput("lit_arst_ready", {63'd0, bus.IDEX_ready}, 64'd0);
    checkOutput("lit_arst_npc", bus.IDEX_npc, 64'd0);
    checkOutput("lit_arst_opcode", bus.opcode, 64'd0);
    checkOutput("lit_arst_rs1", bus.rs1, 64'd0);
    checkOutput("lit_arst_rd", {58'd0, bus.rd}, 64'd0);
    #1 reset = 1'b1;
    applyStimulus(ADDI_X6, 64'h1008, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    checkOutput("lit_x5_cleared", bus.rs1, 64'd0);

    // Load-use hazard: one bubble, then the add issues
    applyStimulus(LD_X5, 64'h2000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    checkOutput("lit_ld_opcode", bus.opcode, 64'h0183);
    setInputs(ADD_X7, 64'h2004, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    #1;
    checkOutput("lit_lu_stall", {63'd0, bus.IDIF_stall}, 64'd1);
    tick();
    checkOutput("lit_lu_bubble", {63'd0, bus.IDEX_ready}, 64'd0);
    checkOutput("lit_lu_stall_clear", {63'd0, bus.IDIF_stall}, 64'd0);
    tick();
    checkOutput("lit_lu_issue", {63'd0, bus.IDEX_ready}, 64'd1);
    checkOutput("lit_lu_npc", bus.IDEX_npc, 64'h2004);

    // Execute stall holds ID/EX for three cycles, then flush wins over stall
    for (int i = 0; i < 3; i++) begin
      setInputs(ADDI_X6, 64'h3000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
      #1;
      checkOutput("lit_hold_stall", {63'd0, bus.IDIF_stall}, 64'd1);
      tick();
      checkOutput("lit_hold_npc", bus.IDEX_npc, 64'h2004);
      checkOutput("lit_hold_opcode", bus.opcode, 64'h0033);
    end
    applyStimulus(ADDI_X6, 64'h3000, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 64'd0);
    checkOutput("lit_flush_ready", {63'd0, bus.IDEX_ready}, 64'd0);

    // Immediate and destination decoding
    applyStimulus(BEQ_M8, 64'h4000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    checkOutput("lit_beq_imm", {44'd0, bus.immediate}, 64'hFFFFC);
    checkOutput("lit_beq_rd5", {63'd0, bus.rd[5]}, 64'd0);
    checkOutput("lit_beq_rs2reg", {58'd0, bus.IDEX_rs2reg}, 64'h22);
    applyStimulus(JAL_800, 64'h4004, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    checkOutput("lit_jal_imm", {44'd0, bus.immediate}, 64'h00400);
    checkOutput("lit_jal_rd", {58'd0, bus.rd}, 64'h21);
    applyStimulus(LUI_X3, 64'h4008, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    checkOutput("lit_lui_imm", {44'd0, bus.immediate}, 64'hABCDE);
    applyStimulus(ADDI_X0, 64'h400C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    checkOutput("lit_x0_rd", {58'd0, bus.rd}, 64'h00);
    applyStimulus(SW_M4, 64'h4010, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    checkOutput("lit_sw_imm", {44'd0, bus.immediate}, 64'hFFFFC);
    applyStimulus(SRAI_X4, 64'h4014, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    checkOutput("lit_srai_opcode", bus.opcode, 64'h8293);
    applyStimulus(BAD_OP, 64'h4018, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    checkOutput("lit_nop_rd", {58'd0, bus.rd}, 64'h00);
    applyStimulus(32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    checkOutput("lit_idle_ready", {63'd0, bus.IDEX_ready}, 64'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_mod.md
Name: decode_mod

Overview:
- Instruction-decode stage of the 5-stage RV64I pipeline, between fetch and execute.
- Registers one 32-bit instruction per cycle into the ID/EX pipeline register: opcode class, register operands, destination, immediate and PC.
- Holds the 32x64 architectural register file, written by writeback.
- Generates load-use stall and branch-flush control.

Parameters:
- XLEN, 64, datapath/register width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- IFID_instreg  input  32  fetched instruction
- IFID_npc  input  64  PC of IFID_instreg
- IFID_ready  input  1  IFID_instreg/IFID_npc valid this cycle
- EXID_stall  input  1  execute cannot accept; hold ID/EX register
- EXIF_branch  input  1  taken branch/jump resolved in execute; flush
- wb_en  input  1  register-file write enable
- wb_rd  input  5  write address
- wb_data  input  64  write data
- IDEX_ready  output  1  ID/EX contents valid
- IDEX_npc  output  64  PC of decoded instruction
- opcode  output  64  {47'b0, funct7[6:0], funct3[2:0], opcode[6:0]}; funct7 zero unless R-type or shift-immediate
- rs1  output  64  rs1 register value
- rs2  output  64  rs2 register value
- rd  output  6  {writes_rd, rd[4:0]}
- immediate  output  20  decoded immediate (see Behaviour)
- IDEX_rs1reg  output  6  {uses_rs1, rs1[4:0]}
- IDEX_rs2reg  output  6  {uses_rs2, rs2[4:0]}
- IDIF_stall  output  1  combinational: fetch must hold its output

Behaviour:
Reset (reset==0, asynchronous):
- All outputs and the ID/EX register clear to 0; IDEX_ready=0.
- Register file clears to 0.

Register file:
- x0 reads 0 and is never written.
- Write on posedge when wb_en && wb_rd!=0.
- Reads are combinational from IFID_instreg[19:15] and [24:20].
- Same-cycle write to a read address bypasses wb_data to the read.

Immediate:
- I/S: 12-bit value sign-extended to 20 bits.
- B: imm[12:1] sign-extended to 20 bits.
- U (LUI/AUIPC): instr[31:12].
- J (JAL): imm[20:1].
- R-type: 0.

Operand usage flags (unsupported opcode → all flags 0, treated as NOP):
- writes_rd = 1 for R, I, U, J, JALR, LOAD, and only when rd!=0.
- uses_rs1 = 1 for R, I, S, B, LOAD, JALR.
- uses_rs2 = 1 for R, S, B.

Load-use hazard:
- Asserted when IDEX_ready, the ID/EX opcode[6:0]==7'b0000011, rd[5]=1, and a used source register of the current IFID instruction equals rd[4:0].

IDIF_stall = EXID_stall | hazard.

Posedge update, first match wins:
1. EXIF_branch: IDEX_ready<=0; current IFID instruction discarded (flush beats stall and hazard).
2. EXID_stall: hold all ID/EX outputs unchanged.
3. hazard: IDEX_ready<=0 (bubble); ID/EX fields may hold stale values.
4. IFID_ready: capture decoded fields and IDEX_npc<=IFID_npc; IDEX_ready<=1.
5. Otherwise: IDEX_ready<=0.

Latency: one cycle from IFID_ready to IDEX_ready.

Test Plan:
- Reset low mid-operation with IDEX_ready=1 → IDEX_ready=0 immediately, all outputs 0; register x5 reads 0 after reset is released.
- Write x5=0x1234 via wb port, then IFID_instreg=0x00528313 (addi x6,x5,5), pc=0x1000 → next cycle:
  - rs1=0x1234
  - immediate=0x00005
  - rd=6'b100110
  - IDEX_rs1reg=6'b100101
  - IDEX_rs2reg[5]=0
  - opcode=0x0013
  - IDEX_npc=0x1000
  - IDEX_ready=1
- Same-cycle wb write of x5=0xAA while decoding add x7,x5,x5 (0x005283B3) → rs1=rs2=0xAA, opcode=0x00033.
- ld x5,0(x1) followed by add x7,x5,x5 → IDIF_stall=1 for one cycle and bubble (IDEX_ready=0); the add issues on the following cycle.
- EXID_stall=1 for 3 cycles → outputs frozen and IDIF_stall=1; EXIF_branch=1 together with EXID_stall=1 → IDEX_ready=0 next cycle.
- Immediate decode:
  - beq offset -8 → immediate=0xFFFFC
  - jal +0x800 → immediate=0x00400
  - lui 0xABCDE → immediate=0xABCDE
  - writes to x0 → rd[5]=0
